// File: rtl/alu32_arbiter_if.sv
// Requester, ALU-side and response signals of alu32_arbiter grouped as one bus.
// Optional ALU_ARB_FLAGS_EN adds the rsp_zero/rsp_carry response flags.
interface alu32_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
);
    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   op0;
    logic [OP_W-1:0]   op1;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    logic              gnt0;
    logic              gnt1;
    logic              alu_en;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
`ifdef ALU_ARB_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_carry;
`endif

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1, alu_result, rsp_ready,
        output gnt0, gnt1, alu_en, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARB_FLAGS_EN
        , output rsp_zero, rsp_carry
`endif
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1, alu_result, rsp_ready,
        input  gnt0, gnt1, alu_en, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARB_FLAGS_EN
        , input rsp_zero, rsp_carry
`endif
    );
endinterface

// File: rtl/alu32_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one command in flight.
// Optional ALU_ARB_FLAGS_EN registers rsp_zero/rsp_carry alongside rsp_data.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch operands on the accepting edge
// EXEC  | alu_en high for one cycle; result captured at the end of it
// RESP  | rsp_valid held until rsp_ready is sampled high
module alu32_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu32_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              alu_en_q, alu_en_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              last_id_q, last_id_d;
    logic              sel;

    // On a tie the requester not served last wins; last_id resets to 1 so req0 wins first.
    assign sel = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;

`ifdef ALU_ARB_FLAGS_EN
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_INC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(3);

    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [DATA_W-1:0] sum_w;
    logic              carry_calc;

    // Carry-out of a+b shows up as a wrapped sum smaller than a; same as bit DATA_W of the wide sum.
    always_comb begin
        sum_w      = alu_a_q + alu_b_q;
        carry_calc = 1'b0;
        case (alu_op_q)
            OP_ADD:  carry_calc = (sum_w < alu_a_q);
            OP_SUB:  carry_calc = (alu_a_q < alu_b_q);
            OP_INC:  carry_calc = (alu_a_q == {DATA_W{1'b1}});
            OP_DEC:  carry_calc = (alu_a_q == '0);
            default: carry_calc = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        alu_en_d    = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        last_id_d   = last_id_q;
`ifdef ALU_ARB_FLAGS_EN
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    alu_op_d = sel ? bus.op1 : bus.op0;
                    alu_a_d  = sel ? bus.a1  : bus.a0;
                    alu_b_d  = sel ? bus.b1  : bus.b0;
                    rsp_id_d = sel;
                    gnt0_d   = ~sel;
                    gnt1_d   = sel;
                    alu_en_d = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_result;
                rsp_valid_d = 1'b1;
                last_id_d   = rsp_id_q;
`ifdef ALU_ARB_FLAGS_EN
                rsp_zero_d  = (bus.alu_result == '0);
                rsp_carry_d = carry_calc;
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            last_id_q   <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            alu_en_q    <= alu_en_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            last_id_q   <= last_id_d;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef ALU_ARB_FLAGS_EN
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_carry = rsp_carry_q;
`endif
endmodule

// File: tb/tb_alu32_arbiter.sv
// Self-checking bench for alu32_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Define ALU_ARB_FLAGS_EN to also check rsp_zero/rsp_carry.
module tb_alu32_arbiter;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    alu32_arbiter_if #(.DATA_W(32), .OP_W(3)) bus ();

    alu32_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 32'd1;
            3'd3:    return a - 32'd1;
            3'd4:    return a;
            3'd5:    return ~a;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

`ifdef ALU_ARB_FLAGS_EN
    function automatic logic ref_carry(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic [32:0] t;
        case (op)
            3'd0:    begin t = {1'b0, a} + {1'b0, b}; return t[32]; end
            3'd1:    return a < b;
            3'd2:    begin t = {1'b0, a} + 33'd1; return t[32]; end
            3'd3:    return a == 32'd0;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Stand-in ALU; the junk value while disabled replaces the floating output.
    assign bus.alu_result = bus.alu_en ? ref_alu(bus.alu_op, bus.alu_a, bus.alu_b) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst_n    = 1'b0;
        #3;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
            bus.op0 = 3'($urandom); bus.op1 = 3'($urandom);
            bus.a0 = $urandom; bus.a1 = $urandom; bus.b0 = $urandom; bus.b1 = $urandom;
            bus.rsp_ready = 1'($urandom);
            tick();
        end
        tests_run++; if ({bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid, bus.rsp_id} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid, bus.rsp_id}); end
        tests_run++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 67'd0) begin
            tests_failed++; $display("FAIL reset_alu_regs got=%h exp=0", {bus.alu_op, bus.alu_a, bus.alu_b}); end
        tests_run++; if (bus.rsp_data !== 32'd0) begin
            tests_failed++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
`ifdef ALU_ARB_FLAGS_EN
        tests_run++; if ({bus.rsp_zero, bus.rsp_carry} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_flags got=%b exp=00", {bus.rsp_zero, bus.rsp_carry}); end
`endif
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if ({bus.gnt0, bus.gnt1, bus.rsp_valid} !== 3'b000) begin
                tests_failed++; $display("FAIL reset_idle_cycle%0d got=%b exp=000", i, {bus.gnt0, bus.gnt1, bus.rsp_valid}); end
        end
    endtask

    task automatic test_single_add();
        bus.rsp_ready = 1'b1;
        bus.req0 = 1'b1; bus.op0 = 3'd0; bus.a0 = 32'd5; bus.b0 = 32'd7;
        tick();
        tests_run++; if ({bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid} !== 4'b1010) begin
            tests_failed++; $display("FAIL single_accept got=%b exp=1010", {bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid}); end
        tests_run++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'd0, 32'd5, 32'd7}) begin
            tests_failed++; $display("FAIL single_latch got=%h exp=%h", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd0, 32'd5, 32'd7}); end
        bus.req0 = 1'b0;
        tick();
        tests_run++; if ({bus.gnt0, bus.alu_en, bus.rsp_valid, bus.rsp_id} !== 4'b0010) begin
            tests_failed++; $display("FAIL single_resp_ctrl got=%b exp=0010", {bus.gnt0, bus.alu_en, bus.rsp_valid, bus.rsp_id}); end
        tests_run++; if (bus.rsp_data !== 32'd12) begin
            tests_failed++; $display("FAIL single_rsp_data got=%h exp=0000000c", bus.rsp_data); end
        tick();
        tests_run++; if (bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_handshake got=%b exp=0", bus.rsp_valid); end
        tick();
    endtask

    task automatic test_tie_alternation();
        int          gq[$];
        int          idq[$];
        logic [31:0] dq[$];
        int          exp_id[4];
        logic [31:0] exp_d[4];
        apply_reset();
        exp_id = '{0, 1, 0, 1};
        exp_d  = '{32'hFF, 32'hD, 32'hFF, 32'hD};
        bus.rsp_ready = 1'b1;
        bus.req0 = 1'b1; bus.op0 = 3'd6; bus.a0 = 32'hF0; bus.b0 = 32'h0F;
        bus.req1 = 1'b1; bus.op1 = 3'd1; bus.a1 = 32'h10; bus.b1 = 32'h3;
        for (int c = 0; c < 40 && dq.size() < 4; c++) begin
            tick();
            if (bus.gnt0) gq.push_back(0);
            if (bus.gnt1) gq.push_back(1);
            if (bus.rsp_valid) begin idq.push_back(int'(bus.rsp_id)); dq.push_back(bus.rsp_data); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tests_run++; if (dq.size() != 4 || gq.size() != 4) begin
            tests_failed++; $display("FAIL tie_counts got=%0d/%0d exp=4/4", gq.size(), dq.size()); end
        for (int i = 0; i < 4 && i < dq.size() && i < gq.size(); i++) begin
            tests_run++; if (gq[i] != exp_id[i] || idq[i] != exp_id[i] || dq[i] !== exp_d[i]) begin
                tests_failed++; $display("FAIL tie_cmd%0d got=gnt%0d id%0d %h exp=%0d %h", i, gq[i], idq[i], dq[i], exp_id[i], exp_d[i]); end
        end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp0, exp1;
        bus.rsp_ready = 1'b0;
        bus.req0 = 1'b1; bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
        exp0 = ref_alu(bus.op0, bus.a0, bus.b0);
        tick();
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b1; bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
        exp1 = ref_alu(bus.op1, bus.a1, bus.b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++; if ({bus.rsp_valid, bus.rsp_id, bus.gnt1} !== 3'b100 || bus.rsp_data !== exp0) begin
                tests_failed++; $display("FAIL stall_cycle%0d got=%b %h exp=100 %h", i, {bus.rsp_valid, bus.rsp_id, bus.gnt1}, bus.rsp_data, exp0); end
        end
        bus.rsp_ready = 1'b1;
        tick();
        tests_run++; if ({bus.rsp_valid, bus.gnt1} !== 2'b00) begin
            tests_failed++; $display("FAIL stall_release got=%b exp=00", {bus.rsp_valid, bus.gnt1}); end
        tick();
        tests_run++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            tests_failed++; $display("FAIL stall_next_gnt got=%b exp=01", {bus.gnt0, bus.gnt1}); end
        bus.req1 = 1'b0;
        tick();
        tests_run++; if ({bus.rsp_valid, bus.rsp_id} !== 2'b11 || bus.rsp_data !== exp1) begin
            tests_failed++; $display("FAIL stall_next_rsp got=%b %h exp=11 %h", {bus.rsp_valid, bus.rsp_id}, bus.rsp_data, exp1); end
        tick(); tick();
    endtask

    task automatic test_wrap();
        logic [2:0]  ops[3];
        logic [31:0] as[3], bs[3], ds[3];
        logic        zs[3], cs[3];
        ops = '{3'd2, 3'd3, 3'd0};
        as  = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        bs  = '{32'h0, 32'h0, 32'h1};
        ds  = '{32'h0, 32'hFFFF_FFFF, 32'h0};
        zs  = '{1'b1, 1'b0, 1'b1};
        cs  = '{1'b1, 1'b1, 1'b1};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0 = 1'b1; bus.op0 = ops[i]; bus.a0 = as[i]; bus.b0 = bs[i];
            tick();
            bus.req0 = 1'b0;
            tick();
            tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ds[i]) begin
                tests_failed++; $display("FAIL wrap%0d got=%b %h exp=1 %h", i, bus.rsp_valid, bus.rsp_data, ds[i]); end
`ifdef ALU_ARB_FLAGS_EN
            tests_run++; if ({bus.rsp_zero, bus.rsp_carry} !== {zs[i], cs[i]}) begin
                tests_failed++; $display("FAIL wrap%0d_flags got=%b exp=%b", i, {bus.rsp_zero, bus.rsp_carry}, {zs[i], cs[i]}); end
`else
            if (zs[i] === 1'bx || cs[i] === 1'bx) $display("wrap table entry %0d incomplete", i);
`endif
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp0;
        bus.rsp_ready = 1'b0;
        bus.req0 = 1'b1; bus.op0 = 3'd4; bus.a0 = 32'h1234_5678; bus.b0 = 32'h0;
        tick();
        bus.req0 = 1'b0;
        tick();
        tests_run++; if (bus.rsp_valid !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre got=%b exp=1", bus.rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if ({bus.rsp_valid, bus.gnt0, bus.alu_en} !== 3'b000 || bus.rsp_data !== 32'd0) begin
            tests_failed++; $display("FAIL midrst_async got=%b %h exp=000 0", {bus.rsp_valid, bus.gnt0, bus.alu_en}, bus.rsp_data); end
        #1 rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0 = 1'b1; bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
        bus.req1 = 1'b1; bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
        exp0 = ref_alu(bus.op0, bus.a0, bus.b0);
        tick();
        tests_run++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            tests_failed++; $display("FAIL midrst_tie got=%b exp=10", {bus.gnt0, bus.gnt1}); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tests_run++; if ({bus.rsp_valid, bus.rsp_id} !== 2'b10 || bus.rsp_data !== exp0) begin
            tests_failed++; $display("FAIL midrst_rsp got=%b %h exp=10 %h", {bus.rsp_valid, bus.rsp_id}, bus.rsp_data, exp0); end
        tick(); tick();
    endtask

    // Model: a command is accepted only when none is outstanding; responses appear one edge
    // after acceptance and retire on the first edge that sees rsp_ready.
    task automatic test_random();
        int          phase;
        logic        last, w, exp_id;
        logic [1:0]  preq, r;
        logic        pready;
        logic [2:0]  cop[2];
        logic [31:0] ca[2], cb[2];
        logic [31:0] exp_data;
        logic        exp_g0, exp_g1;
        apply_reset();
        phase = 0; last = 1'b1; preq = 2'b00; pready = 1'b0; r = 2'b00;
        exp_id = 1'b0; exp_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            exp_g0 = 1'b0; exp_g1 = 1'b0;
            if (phase == 0) begin
                if (preq != 2'b00) begin
                    w = (preq == 2'b11) ? ~last : preq[1];
                    exp_g0 = ~w; exp_g1 = w; exp_id = w; last = w;
                    exp_data = ref_alu(cop[w], ca[w], cb[w]);
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
            end else if (pready) begin
                phase = 0;
            end
            tests_run++; if ({bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid} !== {exp_g0, exp_g1, phase == 1, phase == 2}) begin
                tests_failed++; $display("FAIL rand_ctrl cyc%0d got=%b exp=%b", cyc, {bus.gnt0, bus.gnt1, bus.alu_en, bus.rsp_valid}, {exp_g0, exp_g1, phase == 1, phase == 2}); end
            if (phase == 2) begin
                tests_run++; if (bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
                    tests_failed++; $display("FAIL rand_rsp cyc%0d got=%b %h exp=%b %h", cyc, bus.rsp_id, bus.rsp_data, exp_id, exp_data); end
`ifdef ALU_ARB_FLAGS_EN
                tests_run++; if ({bus.rsp_zero, bus.rsp_carry} !== {exp_data == 32'd0, ref_carry(cop[exp_id], ca[exp_id], cb[exp_id])}) begin
                    tests_failed++; $display("FAIL rand_flags cyc%0d got=%b", cyc, {bus.rsp_zero, bus.rsp_carry}); end
`endif
            end
            for (int i = 0; i < 2; i++) begin
                if (r[i] && (i == 0 ? bus.gnt0 : bus.gnt1)) begin
                    r[i] = 1'b0;
                end else if (!r[i] && $urandom_range(0, 2) == 0) begin
                    r[i] = 1'b1;
                    cop[i] = 3'($urandom_range(0, 7));
                    ca[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF) : $urandom;
                    cb[i] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
                end
            end
            bus.req0 = r[0]; bus.op0 = cop[0]; bus.a0 = ca[0]; bus.b0 = cb[0];
            bus.req1 = r[1]; bus.op1 = cop[1]; bus.a1 = ca[1]; bus.b1 = cb[1];
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            preq = r; pready = bus.rsp_ready;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rsp_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = '0; bus.op1 = '0; bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_tie_alternation();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
